// File: rtl/sw_alloc_if.sv
// ----------------------------------------------------------------------------
// sw_alloc_if : request/grant/credit bundle between the router datapath and
// the wormhole switch allocator.
//
// Handshake: an input presents a flit with req_valid (plus port/ovch/tail).
// The flit crosses the switch in exactly the cycle grant is high for that
// input. req_valid must not depend on grant. A flit whose grant stays low
// remains presented, with the same fields, until it is granted.
//
// Signals
//   req_valid  [NUM_IN]           input i has a flit ready
//   req_port   [3*NUM_IN]         requested output port of input i
//   req_ovch   [2*NUM_IN]         requested output VC of input i
//   req_tail   [NUM_IN]           flit is the last of its packet
//   credit_in  [NUM_OUT*NUM_VC]   one-cycle pulse, one slot freed at (o,v)
//   grant      [NUM_IN]           input i's flit crosses this cycle
//   out_valid  [NUM_OUT]          output o carries a flit this cycle
//   out_sel    [3*NUM_OUT]        input index driving output o
//   out_vch    [2*NUM_OUT]        VC written on output o
//   out_locked [NUM_OUT]          output o held by an in-flight packet
//   err                           sticky error flag
//   dbg_cred   [NUM_OUT*NUM_VC*CW] credit counters, (o,v) at bits [(o*NUM_VC+v)*CW +: CW]
// Modports: master = router datapath / bench, slave = allocator.
// ----------------------------------------------------------------------------
interface sw_alloc_if #(
  parameter int NUM_IN    = 5,
  parameter int NUM_OUT   = 5,
  parameter int NUM_VC    = 4,
  parameter int BUF_DEPTH = 4
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [NUM_IN-1:0]            req_valid;
  logic [3*NUM_IN-1:0]          req_port;
  logic [2*NUM_IN-1:0]          req_ovch;
  logic [NUM_IN-1:0]            req_tail;
  logic [NUM_OUT*NUM_VC-1:0]    credit_in;
  logic [NUM_IN-1:0]            grant;
  logic [NUM_OUT-1:0]           out_valid;
  logic [3*NUM_OUT-1:0]         out_sel;
  logic [2*NUM_OUT-1:0]         out_vch;
  logic [NUM_OUT-1:0]           out_locked;
  logic                         err;
  logic [NUM_OUT*NUM_VC*CW-1:0] dbg_cred;

  modport master (
    output req_valid, req_port, req_ovch, req_tail, credit_in,
    input  grant, out_valid, out_sel, out_vch, out_locked, err, dbg_cred
  );

  modport slave (
    input  req_valid, req_port, req_ovch, req_tail, credit_in,
    output grant, out_valid, out_sel, out_vch, out_locked, err, dbg_cred
  );
endinterface

// File: rtl/sw_alloc.sv
// ----------------------------------------------------------------------------
// sw_alloc : wormhole switch allocator for the hypercube router.
//
// Each output port is granted to one input per packet: round-robin among
// heads while the output is free, then held by the owner until its tail
// flit crosses. A per-(output,VC) credit counter tracks downstream buffer
// space; a flit is only granted when its target VC has a free slot.
// Grants are combinational (same cycle as the request) from registered state.
//
// Ports
//   clk    in  clock, all state on posedge
//   reset  in  asynchronous, active-low; while low no grants are issued
//   bus    sw_alloc_if.slave (requests, credits, grants, output muxing,
//          out_locked, sticky err, dbg_cred exposing the credit counters)
// ----------------------------------------------------------------------------
module sw_alloc #(
  parameter int NUM_IN    = 5,
  parameter int NUM_OUT   = 5,
  parameter int NUM_VC    = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  sw_alloc_if.slave bus
);
  localparam int PW = 3;
  localparam int VW = 2;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  // Registered state per output
  logic [NUM_OUT-1:0]                   r_lock;
  logic [NUM_OUT-1:0][PW-1:0]           r_owner;
  logic [NUM_OUT-1:0][VW-1:0]           r_lvch;
  logic [NUM_OUT-1:0][PW-1:0]           r_rr;
  logic [NUM_OUT-1:0][NUM_VC-1:0][CW-1:0] r_cred;
  logic                                 r_err;

  // Combinational decode / arbitration
  logic [NUM_IN-1:0][PW-1:0]            w_port;
  logic [NUM_IN-1:0][VW-1:0]            w_ovch;
  logic [NUM_OUT-1:0][NUM_IN-1:0]       w_elig;
  logic [NUM_OUT-1:0]                   w_win_v;
  logic [NUM_OUT-1:0][PW-1:0]           w_win;
  logic [NUM_OUT-1:0][VW-1:0]           w_win_vch;
  logic [NUM_OUT-1:0]                   w_win_tail;
  logic [NUM_OUT-1:0][NUM_VC-1:0]       w_cdec;
  logic [NUM_OUT-1:0][NUM_VC-1:0]       w_cinc;
  logic                                 w_err_set;
  logic [NUM_IN-1:0]                    w_grant;
  logic [NUM_OUT-1:0]                   w_out_valid;
  logic [PW*NUM_OUT-1:0]                w_out_sel;
  logic [VW*NUM_OUT-1:0]                w_out_vch;

  // Field unpack and eligibility. Eligibility is forced low while reset is
  // asserted so nothing crosses the switch while the router is flushing.
  always_comb begin
    w_port = '0;
    w_ovch = '0;
    w_elig = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_port[i] = bus.req_port[PW*i +: PW];
      w_ovch[i] = bus.req_ovch[VW*i +: VW];
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        w_elig[o][i] = reset && bus.req_valid[i] && (w_port[i] == PW'(o)) &&
                       (r_cred[o][w_ovch[i]] != '0);
      end
    end
  end

  // Per-output winner selection
  always_comb begin
    int idx;
    idx        = 0;
    w_win_v    = '0;
    w_win      = '0;
    w_win_vch  = '0;
    w_win_tail = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (r_lock[o]) begin
        // Locked: only the owner continuing on the locked VC may proceed.
        for (int i = 0; i < NUM_IN; i++) begin
          if ((PW'(i) == r_owner[o]) && w_elig[o][i] && (w_ovch[i] == r_lvch[o])) begin
            w_win_v[o]    = 1'b1;
            w_win[o]      = PW'(i);
            w_win_vch[o]  = w_ovch[i];
            w_win_tail[o] = bus.req_tail[i];
          end
        end
      end else begin
        // Free: first eligible input starting at the round-robin pointer.
        for (int k = 0; k < NUM_IN; k++) begin
          idx = int'(r_rr[o]) + k;
          if (idx >= NUM_IN) idx = idx - NUM_IN;
          if (!w_win_v[o] && (idx < NUM_IN) && w_elig[o][idx]) begin
            w_win_v[o]    = 1'b1;
            w_win[o]      = PW'(idx);
            w_win_vch[o]  = w_ovch[idx];
            w_win_tail[o] = bus.req_tail[idx];
          end
        end
      end
    end
  end

  // Output muxing, grant vector, credit events and error detection
  always_comb begin
    w_grant     = '0;
    w_out_valid = '0;
    w_out_sel   = '0;
    w_out_vch   = '0;
    w_cdec      = '0;
    w_cinc      = '0;
    w_err_set   = 1'b0;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (w_win_v[o]) begin
        w_out_valid[o]          = 1'b1;
        w_out_sel[PW*o +: PW]   = w_win[o];
        w_out_vch[VW*o +: VW]   = w_win_vch[o];
        for (int i = 0; i < NUM_IN; i++) begin
          if (w_win[o] == PW'(i)) w_grant[i] = 1'b1;
        end
      end
      for (int v = 0; v < NUM_VC; v++) begin
        w_cdec[o][v] = w_win_v[o] && (w_win_vch[o] == VW'(v));
        w_cinc[o][v] = bus.credit_in[o*NUM_VC + v];
        // A credit on a full counter is an overflow unless a grant consumes
        // a slot on the same VC in the same cycle.
        if (w_cinc[o][v] && !w_cdec[o][v] && (r_cred[o][v] == CW'(BUF_DEPTH)))
          w_err_set = 1'b1;
      end
      // Owner of a locked output switching VC mid-packet.
      if (r_lock[o]) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if ((PW'(i) == r_owner[o]) && bus.req_valid[i] &&
              (w_port[i] == PW'(o)) && (w_ovch[i] != r_lvch[o]))
            w_err_set = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.req_valid[i] && (w_port[i] >= PW'(NUM_OUT))) w_err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock  <= '0;
      r_owner <= '0;
      r_lvch  <= '0;
      r_rr    <= '0;
      r_err   <= 1'b0;
      for (int o = 0; o < NUM_OUT; o++) begin
        for (int v = 0; v < NUM_VC; v++) begin
          r_cred[o][v] <= CW'(BUF_DEPTH);
        end
      end
    end else begin
      if (w_err_set) r_err <= 1'b1;
      for (int o = 0; o < NUM_OUT; o++) begin
        for (int v = 0; v < NUM_VC; v++) begin
          if (w_cdec[o][v] && !w_cinc[o][v])
            r_cred[o][v] <= r_cred[o][v] - CW'(1);
          else if (w_cinc[o][v] && !w_cdec[o][v] && (r_cred[o][v] != CW'(BUF_DEPTH)))
            r_cred[o][v] <= r_cred[o][v] + CW'(1);
        end
        if (w_win_v[o]) begin
          if (!r_lock[o]) begin
            r_rr[o] <= (w_win[o] == PW'(NUM_IN-1)) ? '0 : (w_win[o] + PW'(1));
            if (!w_win_tail[o]) begin
              r_lock[o]  <= 1'b1;
              r_owner[o] <= w_win[o];
              r_lvch[o]  <= w_win_vch[o];
            end
          end else if (w_win_tail[o]) begin
            r_lock[o] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.grant      = w_grant;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_sel    = w_out_sel;
  assign bus.out_vch    = w_out_vch;
  assign bus.out_locked = r_lock;
  assign bus.err        = r_err;
  assign bus.dbg_cred   = r_cred;

endmodule
